// File: rtl/rr_prio_encoder.sv
// rr_prio_encoder: registered N-to-log2(N) request encoder with a valid/ready
// output stage. MODE 0 resolves to the highest set request. MODE 1 resolves
// round-robin, starting the scan just past the previous grant.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req        level-sensitive request vector, sampled every clk
//   out_ready  consumer accepts the current result this cycle
//   out_valid  out_idx / out_onehot / multi hold a result
//   out_idx    encoded index of the selected request
//   out_onehot one-hot form of out_idx
//   multi      more than one request was set when the result was captured
module rr_prio_encoder #(
  parameter int unsigned N    = 8,
  parameter int unsigned W    = $clog2(N),
  parameter int unsigned MODE = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot,
  output logic         multi
);

  logic [W-1:0] ptr;
  logic [W-1:0] sel_idx_c;
  logic [W-1:0] ptr_next_c;
  logic [W-1:0] scan_idx_c;
  int unsigned  scan_pos_c;
  logic         found_c;
  logic         load_c;
  logic         multi_c;

  // A new result may be captured when the stage is empty or being drained.
  assign load_c = !out_valid || out_ready;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_c = |(req & (req - N'(1)));

  // Request selection.
  always_comb begin
    sel_idx_c  = '0;
    scan_idx_c = '0;
    scan_pos_c = 0;
    found_c    = 1'b0;
    if (MODE == 0) begin
      // Later (higher) set bits overwrite earlier ones: the top line dominates.
      for (int unsigned i = 0; i < N; i++) begin
        if (req[i]) sel_idx_c = W'(i);
      end
    end else begin
      // Scan ptr, ptr+1, ..., N-1, 0, ..., ptr-1; first hit wins.
      for (int unsigned i = 0; i < N; i++) begin
        scan_pos_c = 32'(ptr) + i;
        if (scan_pos_c >= N) scan_pos_c = scan_pos_c - N;
        scan_idx_c = W'(scan_pos_c);
        if (!found_c && req[scan_idx_c]) begin
          sel_idx_c = scan_idx_c;
          found_c   = 1'b1;
        end
      end
    end
  end

  // Pointer moves just past the grant; explicit wrap covers non-power-of-two N.
  always_comb begin
    ptr_next_c = sel_idx_c + W'(1);
    if (sel_idx_c == W'(N - 1)) ptr_next_c = '0;
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      multi      <= 1'b0;
      ptr        <= '0;
    end else if (load_c) begin
      if (|req) begin
        out_valid  <= 1'b1;
        out_idx    <= sel_idx_c;
        out_onehot <= N'(1) << sel_idx_c;
        multi      <= multi_c;
        if (MODE != 0) ptr <= ptr_next_c;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
